// File: rtl/obi_mem_arbiter.sv
// Two-master OBI arbiter sharing one single-port SRAM: data has priority, bounded by a starvation limit.
// Grant latency 0, response latency 1; one grant per cycle, the losing master simply holds its request.
module obi_mem_arbiter #(
    parameter int unsigned MEM_WORDS       = 4096,
    parameter int unsigned ADDR_W          = $clog2(MEM_WORDS),
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter int unsigned MAX_DATA_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_req_i,
    output logic              instr_gnt_o,
    output logic              instr_rvalid_o,
    input  logic [31:0]       instr_addr_i,
    output logic [31:0]       instr_rdata_o,
    input  logic              data_req_i,
    output logic              data_gnt_o,
    output logic              data_rvalid_o,
    input  logic              data_we_i,
    input  logic [3:0]        data_be_i,
    input  logic [31:0]       data_addr_i,
    input  logic [31:0]       data_wdata_i,
    output logic [31:0]       data_rdata_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_be_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i,
    output logic [15:0]       conflict_cnt_o
);

    // 33-bit end address so a window touching the top of the 4 GiB space does not wrap.
    localparam logic [32:0] END_ADDR   = {1'b0, BASE_ADDR} + 33'(MEM_WORDS) * 33'd4;
    localparam logic [3:0]  STREAK_MAX = 4'(MAX_DATA_STREAK);

    logic [3:0]        streak_cnt;
    logic [15:0]       conflict_cnt;
    logic              resp_v;
    logic              resp_sel;
    logic              resp_rd;

    logic              data_gnt;
    logic              instr_gnt;
    logic              any_gnt;
    logic              in_range;
    logic [31:0]       sel_addr;
    logic [ADDR_W-1:0] word_off;

    always_comb begin
        data_gnt  = !rst && data_req_i && !(instr_req_i && (streak_cnt == STREAK_MAX));
        instr_gnt = !rst && instr_req_i && !data_gnt;
        any_gnt   = data_gnt || instr_gnt;
        sel_addr  = data_gnt ? data_addr_i : instr_addr_i;
        in_range  = (sel_addr >= BASE_ADDR) && ({1'b0, sel_addr} < END_ADDR);
        // BASE_ADDR is aligned to the window size, so subtracting on the word bits alone is exact.
        word_off  = sel_addr[ADDR_W+1:2] - BASE_ADDR[ADDR_W+1:2];

        instr_gnt_o = instr_gnt;
        data_gnt_o  = data_gnt;
        mem_en_o    = any_gnt && in_range;
        mem_we_o    = data_gnt && data_we_i;
        mem_be_o    = data_gnt ? data_be_i : (instr_gnt ? 4'hF : 4'h0);
        mem_addr_o  = any_gnt ? word_off : '0;
        mem_wdata_o = data_gnt ? data_wdata_i : 32'h0;

        instr_rvalid_o = !rst && resp_v && !resp_sel;
        data_rvalid_o  = !rst && resp_v && resp_sel;
        instr_rdata_o  = (instr_rvalid_o && resp_rd) ? mem_rdata_i : 32'h0;
        data_rdata_o   = (data_rvalid_o && resp_rd) ? mem_rdata_i : 32'h0;
        conflict_cnt_o = rst ? 16'h0 : conflict_cnt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            streak_cnt   <= 4'h0;
            conflict_cnt <= 16'h0;
            resp_v       <= 1'b0;
            resp_sel     <= 1'b0;
            resp_rd      <= 1'b0;
        end else begin
            resp_v   <= any_gnt;
            resp_sel <= data_gnt;
            resp_rd  <= any_gnt && in_range && !(data_gnt && data_we_i);

            // Streak only counts data wins while instr is actually waiting.
            if (!instr_req_i || instr_gnt) begin
                streak_cnt <= 4'h0;
            end else if (data_gnt && (streak_cnt != STREAK_MAX)) begin
                streak_cnt <= streak_cnt + 4'h1;
            end

            if (instr_req_i && data_req_i && (conflict_cnt != 16'hFFFF)) begin
                conflict_cnt <= conflict_cnt + 16'h1;
            end
        end
    end

endmodule

// File: tb/tb_obi_mem_arbiter.sv
// Bench for obi_mem_arbiter: directed vector table, hand sequences, and randomized traffic vs a reference model.
module tb_obi_mem_arbiter;

    localparam int WORDS  = 4096;
    localparam int STREAK = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_req_i = 1'b0;
    logic        instr_gnt_o;
    logic        instr_rvalid_o;
    logic [31:0] instr_addr_i = 32'h0;
    logic [31:0] instr_rdata_o;
    logic        data_req_i = 1'b0;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic        data_we_i = 1'b0;
    logic [3:0]  data_be_i = 4'h0;
    logic [31:0] data_addr_i = 32'h0;
    logic [31:0] data_wdata_i = 32'h0;
    logic [31:0] data_rdata_o;
    logic        mem_en_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [11:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic [15:0] conflict_cnt_o;

    obi_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .instr_req_i(instr_req_i), .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
        .instr_addr_i(instr_addr_i), .instr_rdata_o(instr_rdata_o),
        .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
        .data_we_i(data_we_i), .data_be_i(data_be_i), .data_addr_i(data_addr_i),
        .data_wdata_i(data_wdata_i), .data_rdata_o(data_rdata_o),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .conflict_cnt_o(conflict_cnt_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] sram    [WORDS];
    logic [31:0] ref_mem [WORDS];

    function automatic logic [31:0] init_word(int i);
        if (i == 4) return 32'h1234_5678;
        if (i == 8) return 32'h1122_3344;
        if (i == 9) return 32'hCAFE_F00D;
        return 32'h5A00_0000 ^ (32'(i) * 32'h0001_0203);
    endfunction

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] wd, logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        return r;
    endfunction

    function automatic bit model_in_range(logic [31:0] a);
        return {32'h0, a} < 64'(4 * WORDS);
    endfunction

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 7);
        if (r == 0) return 32'h4000 + 32'($urandom_range(0, 1023));
        if (r == 1) return 32'hFFFF_FFFC;
        return 32'($urandom_range(0, 127));
    endfunction

    // Synchronous SRAM: read data appears the cycle after the strobe; junk otherwise.
    initial begin
        for (int i = 0; i < WORDS; i++) sram[i] = init_word(i);
        mem_rdata_i = 32'h0;
        forever begin
            @(posedge clk);
            if (mem_en_o && !mem_we_o) mem_rdata_i <= sram[mem_addr_o];
            else                       mem_rdata_i <= $urandom;
            if (mem_en_o && mem_we_o) sram[mem_addr_o] = merge(sram[mem_addr_o], mem_wdata_o, mem_be_o);
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        instr_req_i = 1'b0;
        data_req_i  = 1'b0;
        data_we_i   = 1'b0;
    endtask

    typedef struct {
        bit          is_d;
        bit          we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          exp_en;
        logic [11:0] exp_maddr;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[8];
    bit   exp_d[12];

    bit          pi, pd, dwe, egd, egi, ein, pv, psel;
    logic [3:0]  dbe;
    logic [31:0] iaddr, daddr, dwd, eaddr, pval;
    int          streak, mconf;

    initial begin
        for (int i = 0; i < WORDS; i++) ref_mem[i] = init_word(i);
        vecs[0] = '{0, 0, 4'h0, 32'h0000_0010, 32'h0,          1, 12'd4, 32'h1234_5678};
        vecs[1] = '{1, 1, 4'h3, 32'h0000_0020, 32'hAABB_CCDD, 1, 12'd8, 32'h0};
        vecs[2] = '{0, 0, 4'h0, 32'h0000_0020, 32'h0,          1, 12'd8, 32'h1122_CCDD};
        vecs[3] = '{1, 0, 4'hF, 32'h0000_4000, 32'h0,          0, 12'd0, 32'h0};
        vecs[4] = '{1, 0, 4'hF, 32'h0000_0027, 32'h0,          1, 12'd9, 32'hCAFE_F00D};
        vecs[5] = '{0, 0, 4'h0, 32'hFFFF_FFFC, 32'h0,          0, 12'd0, 32'h0};
        vecs[6] = '{1, 1, 4'h8, 32'h0000_0010, 32'hEE00_0000, 1, 12'd4, 32'h0};
        vecs[7] = '{1, 0, 4'hF, 32'h0000_0013, 32'h0,          1, 12'd4, 32'hEE34_5678};
        exp_d = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1, 1};

        // Reset with both requests asserted: nothing may be granted or counted.
        instr_req_i = 1'b1; data_req_i = 1'b1; instr_addr_i = 32'h10; data_addr_i = 32'h24;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_instr_gnt", 32'(instr_gnt_o), 32'h0);
        chk("rst_data_gnt", 32'(data_gnt_o), 32'h0);
        chk("rst_mem_en", 32'(mem_en_o), 32'h0);
        chk("rst_rvalid", {30'h0, instr_rvalid_o, data_rvalid_o}, 32'h0);
        chk("rst_conflict", 32'(conflict_cnt_o), 32'h0);
        idle_inputs();
        @(posedge clk); #1 rst = 1'b0;

        // Directed single transactions.
        for (int v = 0; v < 8; v++) begin
            @(posedge clk); #1;
            instr_req_i  = !vecs[v].is_d;
            data_req_i   = vecs[v].is_d;
            instr_addr_i = vecs[v].addr;
            data_addr_i  = vecs[v].addr;
            data_we_i    = vecs[v].we;
            data_be_i    = vecs[v].be;
            data_wdata_i = vecs[v].wdata;
            @(negedge clk);
            chk($sformatf("v%0d_instr_gnt", v), 32'(instr_gnt_o), 32'(!vecs[v].is_d));
            chk($sformatf("v%0d_data_gnt", v), 32'(data_gnt_o), 32'(vecs[v].is_d));
            chk($sformatf("v%0d_mem_en", v), 32'(mem_en_o), 32'(vecs[v].exp_en));
            if (vecs[v].exp_en) begin
                chk($sformatf("v%0d_mem_addr", v), 32'(mem_addr_o), 32'(vecs[v].exp_maddr));
                chk($sformatf("v%0d_mem_we", v), 32'(mem_we_o), 32'(vecs[v].is_d && vecs[v].we));
                chk($sformatf("v%0d_mem_be", v), 32'(mem_be_o), vecs[v].is_d ? 32'(vecs[v].be) : 32'hF);
                chk($sformatf("v%0d_mem_wdata", v), mem_wdata_o, vecs[v].is_d ? vecs[v].wdata : 32'h0);
                if (vecs[v].is_d && vecs[v].we)
                    ref_mem[vecs[v].exp_maddr] = merge(ref_mem[vecs[v].exp_maddr], vecs[v].wdata, vecs[v].be);
            end
            @(posedge clk); #1 idle_inputs();
            @(negedge clk);
            chk($sformatf("v%0d_instr_rvalid", v), 32'(instr_rvalid_o), 32'(!vecs[v].is_d));
            chk($sformatf("v%0d_data_rvalid", v), 32'(data_rvalid_o), 32'(vecs[v].is_d));
            chk($sformatf("v%0d_instr_rdata", v), instr_rdata_o, vecs[v].is_d ? 32'h0 : vecs[v].exp_rdata);
            chk($sformatf("v%0d_data_rdata", v), data_rdata_o, vecs[v].is_d ? vecs[v].exp_rdata : 32'h0);
        end

        // Both requests held 12 cycles: starvation limit forces every fifth grant to instr.
        instr_addr_i = 32'h10; data_addr_i = 32'h24; data_we_i = 1'b0;
        for (int k = 0; k <= 12; k++) begin
            @(posedge clk); #1;
            instr_req_i = (k < 12);
            data_req_i  = (k < 12);
            @(negedge clk);
            if (k < 12) begin
                chk($sformatf("arb%0d_data_gnt", k), 32'(data_gnt_o), 32'(exp_d[k]));
                chk($sformatf("arb%0d_instr_gnt", k), 32'(instr_gnt_o), 32'(!exp_d[k]));
            end
            if (k > 0) begin
                chk($sformatf("arb%0d_data_rvalid", k), 32'(data_rvalid_o), 32'(exp_d[k-1]));
                chk($sformatf("arb%0d_instr_rvalid", k), 32'(instr_rvalid_o), 32'(!exp_d[k-1]));
                chk($sformatf("arb%0d_rdata", k), exp_d[k-1] ? data_rdata_o : instr_rdata_o,
                    exp_d[k-1] ? ref_mem[9] : ref_mem[4]);
            end
        end
        chk("arb_conflict_cnt", 32'(conflict_cnt_o), 32'd12);

        // Reset in the cycle after an instr grant drops the response.
        @(posedge clk); #1 instr_req_i = 1'b1; instr_addr_i = 32'h10;
        @(negedge clk);
        chk("rstmid_gnt", 32'(instr_gnt_o), 32'h1);
        @(posedge clk); #1 begin rst = 1'b1; instr_req_i = 1'b0; end
        @(negedge clk);
        chk("rstmid_rvalid", 32'(instr_rvalid_o), 32'h0);
        chk("rstmid_rdata", instr_rdata_o, 32'h0);
        chk("rstmid_conflict", 32'(conflict_cnt_o), 32'h0);
        @(posedge clk); #1 begin rst = 1'b0; instr_req_i = 1'b1; end
        @(negedge clk);
        chk("rel_first_gnt", 32'(instr_gnt_o), 32'h1);
        chk("rel_mem_en", 32'(mem_en_o), 32'h1);
        chk("rel_no_stale_rvalid", 32'(instr_rvalid_o), 32'h0);
        @(posedge clk); #1 instr_req_i = 1'b0;
        @(negedge clk);
        chk("rel_rvalid", 32'(instr_rvalid_o), 32'h1);
        chk("rel_rdata", instr_rdata_o, ref_mem[4]);
        chk("rel_conflict", 32'(conflict_cnt_o), 32'h0);

        // Randomized OBI traffic against the reference model.
        pi = 0; pd = 0; pv = 0; psel = 0; pval = 0; streak = 0; mconf = 0;
        dwe = 0; dbe = 4'h0; dwd = 0; iaddr = 0; daddr = 0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            if (!pi && $urandom_range(0, 1) == 1) begin pi = 1; iaddr = rand_addr(); end
            if (!pd && $urandom_range(0, 2) != 0) begin
                pd = 1; daddr = rand_addr(); dwe = 1'($urandom_range(0, 1));
                dbe = 4'($urandom_range(1, 15)); dwd = $urandom;
            end
            instr_req_i = pi; instr_addr_i = iaddr;
            data_req_i = pd; data_addr_i = daddr; data_we_i = dwe; data_be_i = dbe; data_wdata_i = dwd;
            @(negedge clk);
            chk("rnd_instr_rvalid", 32'(instr_rvalid_o), 32'(pv && !psel));
            chk("rnd_data_rvalid", 32'(data_rvalid_o), 32'(pv && psel));
            chk("rnd_instr_rdata", instr_rdata_o, (pv && !psel) ? pval : 32'h0);
            chk("rnd_data_rdata", data_rdata_o, (pv && psel) ? pval : 32'h0);

            egd = pd && !(pi && streak == STREAK);
            egi = pi && !egd;
            eaddr = egd ? daddr : iaddr;
            ein = (egd || egi) && model_in_range(eaddr);
            chk("rnd_instr_gnt", 32'(instr_gnt_o), 32'(egi));
            chk("rnd_data_gnt", 32'(data_gnt_o), 32'(egd));
            chk("rnd_mem_en", 32'(mem_en_o), 32'(ein));
            if (ein) begin
                chk("rnd_mem_addr", 32'(mem_addr_o), 32'(eaddr[13:2]));
                chk("rnd_mem_we", 32'(mem_we_o), 32'(egd && dwe));
            end

            if (pi && pd) mconf++;
            if (!pi || egi) streak = 0;
            else if (egd && streak < STREAK) streak++;

            pv = egd || egi;
            psel = egd;
            pval = (ein && !(egd && dwe)) ? ref_mem[eaddr[13:2]] : 32'h0;
            if (ein && egd && dwe) ref_mem[eaddr[13:2]] = merge(ref_mem[eaddr[13:2]], dwd, dbe);
            if (egi) pi = 0;
            if (egd) pd = 0;
        end
        @(posedge clk); #1 idle_inputs();
        @(negedge clk);
        chk("rnd_last_rvalid", {30'h0, instr_rvalid_o, data_rvalid_o}, {30'h0, pv && !psel, pv && psel});
        chk("rnd_conflict_cnt", 32'(conflict_cnt_o), 32'(mconf));

        // Long contention saturates the conflict counter.
        @(posedge clk); #1 begin
            instr_req_i = 1'b1; data_req_i = 1'b1; instr_addr_i = 32'h10; data_addr_i = 32'h24;
        end
        repeat (70000) @(posedge clk);
        @(negedge clk);
        chk("sat_conflict", 32'(conflict_cnt_o), 32'hFFFF);
        @(posedge clk);
        @(negedge clk);
        chk("sat_conflict_hold", 32'(conflict_cnt_o), 32'hFFFF);
        chk("sat_one_gnt", 32'(instr_gnt_o) + 32'(data_gnt_o), 32'h1);
        idle_inputs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
